divider_config_loader: RTL

Host-side configuration sequencer for the pulse divider.
- Accepts 32-bit divider-target and row-points-target load requests over a req/ack handshake, one per requester.
- Arbitrates between the two requesters.
- Clears the selected 32-bit shift register, serializes the value MSB-first onto the shared sr_data/sr_data_clock pins, then issues a divider resync reset.
- Gates the divider count enable while a divider target is being loaded.

---
 rtl/divider_config_loader.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/divider_config_loader.sv
// ---------------------------------------------------------------------------
// divider_config_loader
//
// Purpose:
//   Host-side configuration sequencer for the pulse divider. Two requesters
//   (divider target, row-points target) each hand over a WIDTH-bit value with
//   a req/ack handshake. The winning value is written into its external
//   shift register as follows:
//     1. Clear the register.
//     2. Shift the value out MSB-first on the shared sr_data/sr_data_clock
//        pins.
//     3. Pulse divider_reset so the counters restart on the new target.
//   The divider count enable is gated off while a divider target is loaded.
//
// Ports:
//   sys_clock            system clock, all state on its rising edge
//   external_reset       asynchronous active-high reset
//   div_load_req/_value  divider-target load request and value
//   div_load_ack         one-cycle pulse when a divider load completes
//   row_load_req/_value  row-points-target load request and value
//   row_load_ack         one-cycle pulse when a row load completes
//   cfg_error            one-cycle pulse when a divider value < 2 is rejected
//   run_enable           host run request for the divider
//   divider_enable       gated run enable towards the divider
//   divider_reset        resync reset towards the divider
//   busy                 high while a load transaction is in progress
//   sr_data              serial data, shared by both shift registers
//   sr_data_clock        serial shift clock (registers shift on rising edge)
//   sr_div_data_enable   divider shift-register enable
//   sr_div_data_reset    divider shift-register clear
//   sr_row_data_enable   row shift-register enable
//   sr_row_data_reset    row shift-register clear
// ---------------------------------------------------------------------------
module divider_config_loader #(
  parameter int WIDTH         = 32,
  parameter int HALF_PERIOD   = 4,
  parameter int CLEAR_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             sys_clock,
  input  logic             external_reset,
  input  logic             div_load_req,
  input  logic [WIDTH-1:0] div_load_value,
  output logic             div_load_ack,
  input  logic             row_load_req,
  input  logic [WIDTH-1:0] row_load_value,
  output logic             row_load_ack,
  output logic             cfg_error,
  input  logic             run_enable,
  output logic             divider_enable,
  output logic             divider_reset,
  output logic             busy,
  output logic             sr_data,
  output logic             sr_data_clock,
  output logic             sr_div_data_enable,
  output logic             sr_div_data_reset,
  output logic             sr_row_data_enable,
  output logic             sr_row_data_reset
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_TAIL     = 3'd4,
    S_RESYNC   = 3'd5,
    S_ACK      = 3'd6
  } state_t;

  // Control state
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;      // cycles spent in the current phase
  logic [BIT_W-1:0]   bit_q, bit_d;      // index of the bit being shifted
  logic [WIDTH-1:0]   value_q, value_d;  // value latched on acceptance
  logic               grant_div_q, grant_div_d;
  logic               grant_row_q, grant_row_d;
  logic               reject_d;

  // Registered outputs
  logic div_load_ack_q,       div_load_ack_d;
  logic row_load_ack_q,       row_load_ack_d;
  logic cfg_error_q,          cfg_error_d;
  logic divider_enable_q,     divider_enable_d;
  logic divider_reset_q,      divider_reset_d;
  logic busy_q,               busy_d;
  logic sr_data_q,            sr_data_d;
  logic sr_data_clock_q,      sr_data_clock_d;
  logic sr_div_data_enable_q, sr_div_data_enable_d;
  logic sr_div_data_reset_q,  sr_div_data_reset_d;
  logic sr_row_data_enable_q, sr_row_data_enable_d;
  logic sr_row_data_reset_q,  sr_row_data_reset_d;

  logic in_shift_d;   // next state is SHIFT_LO, SHIFT_HI or TAIL
  logic gating_q;     // current state blocks the divider count enable

  // -------------------------------------------------------------------------
  // State register: control state and all registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clock or posedge external_reset) begin
    if (external_reset) begin
      state_q              <= S_IDLE;
      cnt_q                <= '0;
      bit_q                <= '0;
      value_q              <= '0;
      grant_div_q          <= 1'b0;
      grant_row_q          <= 1'b0;
      div_load_ack_q       <= 1'b0;
      row_load_ack_q       <= 1'b0;
      cfg_error_q          <= 1'b0;
      divider_enable_q     <= 1'b0;
      divider_reset_q      <= 1'b0;
      busy_q               <= 1'b0;
      sr_data_q            <= 1'b0;
      sr_data_clock_q      <= 1'b0;
      sr_div_data_enable_q <= 1'b0;
      sr_div_data_reset_q  <= 1'b0;
      sr_row_data_enable_q <= 1'b0;
      sr_row_data_reset_q  <= 1'b0;
    end else begin
      state_q              <= state_d;
      cnt_q                <= cnt_d;
      bit_q                <= bit_d;
      value_q              <= value_d;
      grant_div_q          <= grant_div_d;
      grant_row_q          <= grant_row_d;
      div_load_ack_q       <= div_load_ack_d;
      row_load_ack_q       <= row_load_ack_d;
      cfg_error_q          <= cfg_error_d;
      divider_enable_q     <= divider_enable_d;
      divider_reset_q      <= divider_reset_d;
      busy_q               <= busy_d;
      sr_data_q            <= sr_data_d;
      sr_data_clock_q      <= sr_data_clock_d;
      sr_div_data_enable_q <= sr_div_data_enable_d;
      sr_div_data_reset_q  <= sr_div_data_reset_d;
      sr_row_data_enable_q <= sr_row_data_enable_d;
      sr_row_data_reset_q  <= sr_row_data_reset_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    value_d     = value_q;
    grant_div_d = grant_div_q;
    grant_row_d = grant_row_q;
    reject_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A rejected divider request still uses up this cycle, so a
        // simultaneous row request is taken on a later IDLE cycle.
        if (div_load_req) begin
          if (div_load_value < WIDTH'(2)) begin
            reject_d = 1'b1;
          end else begin
            value_d     = div_load_value;
            grant_div_d = 1'b1;
            grant_row_d = 1'b0;
            bit_d       = BIT_W'(WIDTH - 1);
            cnt_d       = '0;
            state_d     = S_CLEAR;
          end
        end else if (row_load_req) begin
          value_d     = row_load_value;
          grant_div_d = 1'b0;
          grant_row_d = 1'b1;
          bit_d       = BIT_W'(WIDTH - 1);
          cnt_d       = '0;
          state_d     = S_CLEAR;
        end
      end

      S_CLEAR: begin
        if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SHIFT_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SHIFT_LO: begin
        if (cnt_q == CNT_W'(HALF_PERIOD - 1)) begin
          cnt_d   = '0;
          state_d = S_SHIFT_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SHIFT_HI: begin
        if (cnt_q == CNT_W'(HALF_PERIOD - 1)) begin
          cnt_d = '0;
          if (bit_q == '0) begin
            state_d = S_TAIL;
          end else begin
            bit_d   = bit_q - BIT_W'(1);
            state_d = S_SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_TAIL: begin
        if (cnt_q == CNT_W'(HALF_PERIOD - 1)) begin
          cnt_d   = '0;
          state_d = S_RESYNC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESYNC: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ACK: begin
        grant_div_d = 1'b0;
        grant_row_d = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        grant_div_d = 1'b0;
        grant_row_d = 1'b0;
        cnt_d       = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: outputs are derived from the next state so that each
  // registered output lines up exactly with the state it belongs to.
  // -------------------------------------------------------------------------
  always_comb begin
    in_shift_d = (state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI) ||
                 (state_d == S_TAIL);

    gating_q = grant_div_q &&
               ((state_q == S_CLEAR)    || (state_q == S_SHIFT_LO) ||
                (state_q == S_SHIFT_HI) || (state_q == S_TAIL)     ||
                (state_q == S_RESYNC));

    sr_div_data_reset_d  = grant_div_d && (state_d == S_CLEAR);
    sr_row_data_reset_d  = grant_row_d && (state_d == S_CLEAR);
    sr_div_data_enable_d = grant_div_d && in_shift_d;
    sr_row_data_enable_d = grant_row_d && in_shift_d;
    sr_data_clock_d      = (state_d == S_SHIFT_HI);
    divider_reset_d      = (state_d == S_RESYNC);
    div_load_ack_d       = grant_div_d && (state_d == S_ACK);
    row_load_ack_d       = grant_row_d && (state_d == S_ACK);
    busy_d               = (state_d != S_IDLE);
    cfg_error_d          = reject_d;

    // Gating looks at the current state, so the divider sees it one cycle
    // after the state changes.
    divider_enable_d = run_enable && !gating_q;

    // A new bit is presented only when SHIFT_LO is entered; it then stays put
    // through SHIFT_HI (and TAIL for the last bit) so it is stable a full
    // half-period around each rising shift clock.
    if ((state_d == S_SHIFT_LO) && (state_q != S_SHIFT_LO)) begin
      sr_data_d = value_d[bit_d];
    end else if (in_shift_d) begin
      sr_data_d = sr_data_q;
    end else begin
      sr_data_d = 1'b0;
    end
  end

  assign div_load_ack       = div_load_ack_q;
  assign row_load_ack       = row_load_ack_q;
  assign cfg_error          = cfg_error_q;
  assign divider_enable     = divider_enable_q;
  assign divider_reset      = divider_reset_q;
  assign busy               = busy_q;
  assign sr_data            = sr_data_q;
  assign sr_data_clock      = sr_data_clock_q;
  assign sr_div_data_enable = sr_div_data_enable_q;
  assign sr_div_data_reset  = sr_div_data_reset_q;
  assign sr_row_data_enable = sr_row_data_enable_q;
  assign sr_row_data_reset  = sr_row_data_reset_q;

endmodule
